// File: rtl/issue_scheduler.sv
// Instruction-buffer slot manager and round-robin issue selector.
// Tracks every buffer slot through FREE -> WAIT -> ISSUED -> FREE, hands out
// the lowest free slot for allocation, and offers one ready instruction per
// cycle to the execution unit over a valid/ready handshake.
module issue_scheduler #(
    parameter  int bs = 16,
    localparam int IW = $clog2(bs)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [0:bs-1] independent_instr,
    input  logic          alloc_valid,
    output logic          alloc_ready,
    output logic [IW-1:0] alloc_index,
    output logic          issue_valid,
    input  logic          issue_ready,
    output logic [IW-1:0] issue_index,
    input  logic          cmpl_valid,
    input  logic [IW-1:0] cmpl_index,
    output logic [0:bs-1] busy_mask,
    output logic          full,
    output logic          empty,
    output logic          err
);

    typedef enum logic [1:0] {
        S_FREE   = 2'b00,
        S_WAIT   = 2'b01,
        S_ISSUED = 2'b10
    } slot_state_e;

    slot_state_e   r_state      [bs];
    slot_state_e   w_state_next [bs];
    logic          r_issue_valid;
    logic [IW-1:0] r_issue_index;
    logic [IW-1:0] r_rr_ptr;
    logic          r_err;

    logic [0:bs-1] w_free;
    logic [0:bs-1] w_cand;
    logic          w_alloc_ready;
    logic [IW-1:0] w_alloc_index;
    logic          w_found;
    logic [IW-1:0] w_sel;
    logic [IW-1:0] w_probe;
    logic          w_load;
    logic          w_issue_fire;
    logic          w_alloc_fire;
    logic          w_cmpl_bad;

    // Classify each slot: free for allocation, or a ready issue candidate.
    always_comb begin
        w_free = '0;
        w_cand = '0;
        for (int j = 0; j < bs; j++) begin
            w_free[j] = (r_state[j] == S_FREE);
            w_cand[j] = (r_state[j] == S_WAIT) && independent_instr[j];
        end
    end

    // Lowest-numbered free slot (scan downwards so the lowest index wins).
    always_comb begin
        w_alloc_index = '0;
        for (int j = bs - 1; j >= 0; j--) begin
            w_alloc_index = w_free[j] ? IW'(j) : w_alloc_index;
        end
    end

    // Round-robin pick: first candidate starting at rr_ptr, wrapping modulo bs.
    always_comb begin
        w_found = 1'b0;
        w_sel   = r_rr_ptr;
        w_probe = r_rr_ptr;
        for (int k = 0; k < bs; k++) begin
            w_probe = r_rr_ptr + IW'(k);
            if (!w_found && w_cand[w_probe]) begin
                w_found = 1'b1;
                w_sel   = w_probe;
            end else begin
                w_found = w_found;
                w_sel   = w_sel;
            end
        end
    end

    assign w_alloc_ready = |w_free;
    assign w_alloc_fire  = alloc_valid && w_alloc_ready;
    // The output register may take a new slot when empty or when the held one is accepted.
    assign w_load        = !r_issue_valid || issue_ready;
    assign w_issue_fire  = w_load && w_found;
    // Completion is only legal for a slot already handed to execution.
    assign w_cmpl_bad    = cmpl_valid && (r_state[cmpl_index] != S_ISSUED);

    // Per-slot next state. Alloc, issue and completion target slots in distinct
    // states, so all three can land in the same cycle without conflict.
    always_comb begin
        for (int j = 0; j < bs; j++) begin
            w_state_next[j] = r_state[j];
            case (r_state[j])
                S_FREE: begin
                    if (w_alloc_fire && (w_alloc_index == IW'(j))) begin
                        w_state_next[j] = S_WAIT;
                    end else begin
                        w_state_next[j] = S_FREE;
                    end
                end
                S_WAIT: begin
                    if (w_issue_fire && (w_sel == IW'(j))) begin
                        w_state_next[j] = S_ISSUED;
                    end else begin
                        w_state_next[j] = S_WAIT;
                    end
                end
                S_ISSUED: begin
                    if (cmpl_valid && (cmpl_index == IW'(j))) begin
                        w_state_next[j] = S_FREE;
                    end else begin
                        w_state_next[j] = S_ISSUED;
                    end
                end
                default: w_state_next[j] = S_FREE;
            endcase
        end
    end

    // Slot state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < bs; j++) begin
                r_state[j] <= S_FREE;
            end
        end else begin
            for (int j = 0; j < bs; j++) begin
                r_state[j] <= w_state_next[j];
            end
        end
    end

    // Issue output register and round-robin pointer; held stable while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_issue_valid <= 1'b0;
            r_issue_index <= '0;
            r_rr_ptr      <= '0;
        end else if (w_load) begin
            if (w_found) begin
                r_issue_valid <= 1'b1;
                r_issue_index <= w_sel;
                r_rr_ptr      <= w_sel + IW'(1);
            end else begin
                r_issue_valid <= 1'b0;
            end
        end
    end

    // Sticky flag for completions that name a slot not in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_cmpl_bad) begin
            r_err <= 1'b1;
        end
    end

    assign alloc_ready = w_alloc_ready;
    assign alloc_index = w_alloc_index;
    assign issue_valid = r_issue_valid;
    assign issue_index = r_issue_index;
    assign busy_mask   = ~w_free;
    assign full        = ~w_alloc_ready;
    assign empty       = (&w_free) && !r_issue_valid;
    assign err         = r_err;

endmodule
